// File: rtl/valid_counter.sv
// valid_counter: up-counter that advances on each cycle with valid high, rolling over after MAX_COUNT.
// Latency: one cycle from valid at an edge to count/wrap updating; at_max is a combinational decode of count.
// Backpressure: none; valid is a pure count enable and may have gaps of any length.
// Optional build macro COUNTER_SATURATE_EN: hold at MAX_COUNT instead of wrapping (wrap stays 0).
module valid_counter #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max
);

    // Terminal decode is purely from the registered count, so it is not gated by valid.
    assign at_max = (count == MAX_COUNT);

    // Count register and wrap pulse: reset first, then valid, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (valid) begin
            if (at_max) begin
`ifdef COUNTER_SATURATE_EN
                // Saturating build: stick at the terminal value until reset.
                count <= count;
                wrap  <= 1'b0;
`else
                // Wrapping build: roll back to zero and flag it for one cycle.
                count <= '0;
                wrap  <= 1'b1;
`endif
            end else begin
                count <= count + 1'b1;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_valid_counter.sv
// Testbench for valid_counter: a full-range 8-bit instance and a 4-bit instance with MAX_COUNT=9.
// Expected values come from a vector table and a small reference model, queued at drive time.
// Outputs are popped and compared 1 ns after each rising edge.
module tb_valid_counter;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] count8;
    logic       wrap8;
    logic       at_max8;
    logic [3:0] count9;
    logic       wrap9;
    logic       at_max9;

    int checks = 0;
    int errors = 0;

    valid_counter #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .count  (count8),
        .wrap   (wrap8),
        .at_max (at_max8)
    );

    valid_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) dut9 (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .count  (count9),
        .wrap   (wrap9),
        .at_max (at_max9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] count;
        logic       wrap;
        logic       at_max;
    } vec_t;

    typedef struct {
        logic [7:0] count8;
        logic       wrap8;
        logic       at_max8;
        logic [3:0] count9;
        logic       wrap9;
        logic       at_max9;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m8 = '0;
    logic       mw8 = 1'b0;
    logic [3:0] m9 = '0;
    logic       mw9 = 1'b0;
    int         wrap9_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, queue the expectation, then compare after the edge.
    task automatic cycle(input logic r, input logic v, input logic use_tbl, input vec_t tv);
        exp_t e;
        rst   = r;
        valid = v;
        if (r) begin
            m8 = '0; mw8 = 1'b0;
            m9 = '0; mw9 = 1'b0;
        end else if (v) begin
            if (m8 == 8'd255) begin
`ifdef COUNTER_SATURATE_EN
                mw8 = 1'b0;
`else
                m8 = '0; mw8 = 1'b1;
`endif
            end else begin
                m8 = m8 + 8'd1; mw8 = 1'b0;
            end
            if (m9 == 4'd9) begin
`ifdef COUNTER_SATURATE_EN
                mw9 = 1'b0;
`else
                m9 = '0; mw9 = 1'b1;
`endif
            end else begin
                m9 = m9 + 4'd1; mw9 = 1'b0;
            end
        end else begin
            mw8 = 1'b0;
            mw9 = 1'b0;
        end
        e.count8  = m8;
        e.wrap8   = mw8;
        e.at_max8 = (m8 == 8'd255);
        e.count9  = m9;
        e.wrap9   = mw9;
        e.at_max9 = (m9 == 4'd9);
        if (use_tbl) begin
            e.count8  = tv.count;
            e.wrap8   = tv.wrap;
            e.at_max8 = tv.at_max;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("count8",  32'(count8),  32'(e.count8));
        check("wrap8",   32'(wrap8),   32'(e.wrap8));
        check("at_max8", 32'(at_max8), 32'(e.at_max8));
        check("count9",  32'(count9),  32'(e.count9));
        check("wrap9",   32'(wrap9),   32'(e.wrap9));
        check("at_max9", 32'(at_max9), 32'(e.at_max9));
        if (wrap9) wrap9_seen++;
    endtask

    task automatic step(input logic r, input logic v);
        vec_t dummy;
        dummy = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        cycle(r, v, 1'b0, dummy);
    endtask

    vec_t tbl[9];

    initial begin
        // {rst, valid, count, wrap, at_max} for the 8-bit instance.
        tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'd2, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'd1, 1'b0, 1'b0};

        rst   = 1'b1;
        valid = 1'b0;
        wrap9_seen = 0;

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].rst, tbl[i].valid, 1'b1, tbl[i]);
        end

        // Run / hold / run.
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("hold_count8", 32'(count8), 32'd10);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check("run_count8", 32'(count8), 32'd16);

        // Terminal value, rollover (or saturation), and continued counting.
        step(1'b1, 1'b0);
        for (int i = 0; i < 255; i++) step(1'b0, 1'b1);
        check("max_count8", 32'(count8), 32'd255);
        check("max_at_max8", 32'(at_max8), 32'd1);
        step(1'b0, 1'b1);
`ifdef COUNTER_SATURATE_EN
        check("sat_count8", 32'(count8), 32'd255);
        check("sat_wrap8", 32'(wrap8), 32'd0);
`else
        check("roll_count8", 32'(count8), 32'd0);
        check("roll_wrap8", 32'(wrap8), 32'd1);
`endif
        step(1'b0, 1'b0);
        check("wrap8_one_cycle", 32'(wrap8), 32'd0);
        for (int i = 0; i < 44; i++) step(1'b0, 1'b1);
`ifdef COUNTER_SATURATE_EN
        check("after300_count8", 32'(count8), 32'd255);
`else
        check("after300_count8", 32'(count8), 32'd44);
`endif

        // Custom terminal value on the MAX_COUNT=9 instance.
        step(1'b1, 1'b0);
        wrap9_seen = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
`ifdef COUNTER_SATURATE_EN
        check("term_count9", 32'(count9), 32'd9);
        check("term_wraps9", 32'(wrap9_seen), 32'd0);
`else
        check("term_count9", 32'(count9), 32'd2);
        check("term_wraps9", 32'(wrap9_seen), 32'd1);
`endif

        // Reset mid-count overrides a simultaneous valid.
        step(1'b1, 1'b0);
        for (int i = 0; i < 37; i++) step(1'b0, 1'b1);
        check("mid_count8", 32'(count8), 32'd37);
        step(1'b1, 1'b1);
        check("mid_rst_count8", 32'(count8), 32'd0);
        step(1'b0, 1'b1);
        check("post_rst_count8", 32'(count8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
